// File: rtl/dtw_pkg.sv
// Shared DTW definitions: sequencer state encodings, default geometry and the INF cost value.
package dtw_pkg;

  localparam int DTW_N    = 16;
  localparam int DTW_R    = 2;
  localparam int DTW_PIPE = 2;
  localparam int COST_W   = 16;

  // Saturated "unreachable" cost the PE substitutes for missing neighbours.
  localparam logic [COST_W-1:0] COST_INF = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dtw_band_counter.sv
// Row/slot counters for the band walk; exposes the upcoming slot's column and band flags
// so the controller can register them, plus a last-slot flag for the current slot.
module dtw_band_counter #(
  parameter int N      = 16,
  parameter int R      = 2,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              adv,
  output logic              last_slot,
  output logic [ADDR_W-1:0] nxt_ref,
  output logic [ADDR_W-1:0] nxt_qry,
  output logic              nxt_cell_valid,
  output logic              nxt_row_start,
  output logic              nxt_first_row,
  output logic              nxt_first_col,
  output logic              nxt_last_cell
);

  localparam int W  = 2 * R + 1;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int JW = ((ADDR_W > KW) ? ADDR_W : KW) + 2;

  localparam logic [ADDR_W-1:0]    I_LAST = ADDR_W'(N - 1);
  localparam logic [KW-1:0]        K_LAST = KW'(W - 1);
  localparam logic [JW-1:0]        R_OFF  = JW'(R);
  localparam logic [JW-1:0]        J_LAST = JW'(N - 1);
  localparam logic signed [JW-1:0] J_LIM  = JW'(N);

  logic [ADDR_W-1:0]    i_q, i_n;
  logic [KW-1:0]        k_q, k_n;
  logic [JW-1:0]        j_raw;
  logic signed [JW-1:0] j_s;

  assign last_slot = (i_q == I_LAST) && (k_q == K_LAST);

  always_comb begin
    i_n = i_q;
    k_n = k_q;
    if (clear) begin
      i_n = '0;
      k_n = '0;
    end else if (adv) begin
      if (k_q == K_LAST) begin
        k_n = '0;
        i_n = i_q + 1'b1;
      end else begin
        k_n = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_n;
      k_q <= k_n;
    end
  end

  // j = i - R + k; the extra headroom keeps negative columns distinguishable from wrap-around.
  assign j_raw = JW'(i_n) + JW'(k_n) - R_OFF;
  assign j_s   = signed'(j_raw);

  assign nxt_cell_valid = !j_s[JW-1] && (j_s < J_LIM);
  assign nxt_ref        = i_n;
  assign nxt_qry        = nxt_cell_valid ? j_raw[ADDR_W-1:0] : '0;
  assign nxt_row_start  = (k_n == '0);
  assign nxt_first_row  = nxt_cell_valid && (i_n == '0);
  assign nxt_first_col  = nxt_cell_valid && (j_raw == '0);
  assign nxt_last_cell  = nxt_cell_valid && (i_n == I_LAST) && (j_raw == J_LAST);

endmodule

// File: rtl/dtw_band_ctrl.sv
// Band sequencer: on start walks W=2R+1 slots per row over N rows, then drains PIPE cycles and pulses done.
// All outputs are registered from next-state values; shift_en alone combines the live stall input.
module dtw_band_ctrl
  import dtw_pkg::*;
#(
  parameter int N      = DTW_N,
  parameter int R      = DTW_R,
  parameter int PIPE   = DTW_PIPE,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [ADDR_W-1:0] qry_addr,
  output logic              slot_valid,
  output logic              cell_valid,
  output logic              shift_en,
  output logic              row_start,
  output logic              first_row,
  output logic              first_col,
  output logic              last_cell
);

  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE - 1);

  logic [2:0]        state_q, state_n;
  logic [DW-1:0]     drain_q;
  logic              clear, adv, last_slot, run_n;
  logic [ADDR_W-1:0] nxt_ref, nxt_qry;
  logic              nxt_cell_valid, nxt_row_start, nxt_first_row, nxt_first_col, nxt_last_cell;

  dtw_band_counter #(
    .N      (N),
    .R      (R),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .adv            (adv),
    .last_slot      (last_slot),
    .nxt_ref        (nxt_ref),
    .nxt_qry        (nxt_qry),
    .nxt_cell_valid (nxt_cell_valid),
    .nxt_row_start  (nxt_row_start),
    .nxt_first_row  (nxt_first_row),
    .nxt_first_col  (nxt_first_col),
    .nxt_last_cell  (nxt_last_cell)
  );

  always_comb begin
    state_n = state_q;
    clear   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        clear   = 1'b1;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (last_slot) state_n = (PIPE == 0) ? ST_DONE : ST_DRAIN;
          else           adv     = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) state_n = ST_IDLE;
  end

  assign run_n = (state_n == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_n;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  // Slot outputs follow the counter's upcoming slot, so a stall simply reloads identical values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      slot_valid <= 1'b0;
      ref_addr   <= '0;
      qry_addr   <= '0;
      cell_valid <= 1'b0;
      row_start  <= 1'b0;
      first_row  <= 1'b0;
      first_col  <= 1'b0;
      last_cell  <= 1'b0;
    end else begin
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
      slot_valid <= run_n;
      ref_addr   <= run_n ? nxt_ref : '0;
      qry_addr   <= run_n ? nxt_qry : '0;
      cell_valid <= run_n && nxt_cell_valid;
      row_start  <= run_n && nxt_row_start;
      first_row  <= run_n && nxt_first_row;
      first_col  <= run_n && nxt_first_col;
      last_cell  <= run_n && nxt_last_cell;
    end
  end

  assign shift_en = slot_valid && !stall;

endmodule

// File: tb/tb_dtw_band_ctrl.sv
// Directed bench for dtw_band_ctrl: slot table for N=4,R=1 plus stall/abort/restart/reset sequences and an N=4,R=4 run.
module tb_dtw_band_ctrl;

  logic       clk, rst_n, start, start2, abort, stall;
  logic       busy, done, slot_valid, cell_valid, shift_en, row_start, first_row, first_col, last_cell;
  logic [1:0] ref_addr, qry_addr;
  logic       busy2, done2, slot_valid2, cell_valid2, shift_en2, row_start2, first_row2, first_col2, last_cell2;
  logic [1:0] ref_addr2, qry_addr2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int ref_a;
    int qry_a;
    bit cv;
    bit rs;
    bit fr;
    bit fc;
    bit lc;
  } slot_t;

  slot_t tbl [12];

  dtw_band_ctrl #(.N(4), .R(1), .PIPE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .busy(busy), .done(done), .ref_addr(ref_addr), .qry_addr(qry_addr),
    .slot_valid(slot_valid), .cell_valid(cell_valid), .shift_en(shift_en),
    .row_start(row_start), .first_row(first_row), .first_col(first_col), .last_cell(last_cell)
  );

  dtw_band_ctrl #(.N(4), .R(4), .PIPE(2)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .stall(stall),
    .busy(busy2), .done(done2), .ref_addr(ref_addr2), .qry_addr(qry_addr2),
    .slot_valid(slot_valid2), .cell_valid(cell_valid2), .shift_en(shift_en2),
    .row_start(row_start2), .first_row(first_row2), .first_col(first_col2), .last_cell(last_cell2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " slot_valid"}, slot_valid, 0);
    chk({tag, " cell_valid"}, cell_valid, 0);
    chk({tag, " shift_en"}, shift_en, 0);
    chk({tag, " ref_addr"}, ref_addr, 0);
    chk({tag, " qry_addr"}, qry_addr, 0);
    chk({tag, " row_start"}, row_start, 0);
    chk({tag, " first_row"}, first_row, 0);
    chk({tag, " first_col"}, first_col, 0);
    chk({tag, " last_cell"}, last_cell, 0);
  endtask

  task automatic check_slot(input int s, input int exp_shift);
    chk("slot busy", busy, 1);
    chk("slot done", done, 0);
    chk("slot_valid", slot_valid, 1);
    chk("ref_addr", ref_addr, tbl[s].ref_a);
    chk("qry_addr", qry_addr, tbl[s].qry_a);
    chk("cell_valid", cell_valid, tbl[s].cv);
    chk("row_start", row_start, tbl[s].rs);
    chk("first_row", first_row, tbl[s].fr);
    chk("first_col", first_col, tbl[s].fc);
    chk("last_cell", last_cell, tbl[s].lc);
    chk("shift_en", shift_en, exp_shift);
  endtask

  // Full run from a start pulse, optionally stalling stall_len cycles on slot stall_slot.
  task automatic run_check(input int stall_slot, input int stall_len, input int exp_done);
    int cells, got, ndone;
    cells = 0;
    got   = -1;
    ndone = 0;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    chk("load busy", busy, 1);
    chk("load slot_valid", slot_valid, 0);
    for (int s = 0; s < 12; s++) begin
      tick();
      if (s == 0) chk("first slot cycle", cyc, 2);
      if (s == stall_slot) begin
        for (int r = 0; r < stall_len; r++) begin
          stall = 1'b1;
          #1;
          check_slot(s, 0);
          tick();
        end
      end
      stall = 1'b0;
      #1;
      check_slot(s, 1);
      if (cell_valid) cells++;
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done) begin
        ndone++;
        if (got < 0) got = cyc;
      end
      if (got < 0) chk("drain busy", busy, 1);
    end
    chk("cell count", cells, 10);
    chk("done cycle", got, exp_done);
    chk("done pulses", ndone, 1);
    chk("post busy", busy, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 1, 1, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 1, 0, 1, 0};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 2, 1, 0, 0, 0, 0};
    tbl[6]  = '{2, 1, 1, 1, 0, 0, 0};
    tbl[7]  = '{2, 2, 1, 0, 0, 0, 0};
    tbl[8]  = '{2, 3, 1, 0, 0, 0, 0};
    tbl[9]  = '{3, 2, 1, 1, 0, 0, 0};
    tbl[10] = '{3, 3, 1, 0, 0, 0, 1};
    tbl[11] = '{3, 0, 0, 0, 0, 0, 0};

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    abort  = 1'b0;
    stall  = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    chk("reset busy2", busy2, 0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: clean run.
    run_check(-1, 0, 16);

    // Scenario 2: 3-cycle stall on slot (1,1).
    run_check(4, 3, 19);

    // Start together with abort while idle stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_quiet("start+abort");
    tick();
    check_quiet("start+abort next");

    // Scenario 3: abort on cycle 6, then a normal run.
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_quiet("abort");
    begin
      int nd;
      nd = 0;
      for (int n = 0; n < 20; n++) begin
        tick();
        if (done || busy) nd++;
      end
      chk("abort no done", nd, 0);
    end
    run_check(-1, 0, 16);

    // Scenario 4: start re-pulsed at cycles 5 and 16 has no effect.
    begin
      int nd, bad_busy;
      nd       = 0;
      bad_busy = 0;
      start    = 1'b1;
      cyc      = 0;
      tick();
      start = 1'b0;
      while (cyc < 21) begin
        start = (cyc == 5) || (cyc == 16);
        if (done) begin
          nd++;
          chk("repulse done cycle", cyc, 16);
        end
        if (busy != ((cyc >= 1) && (cyc <= 16))) bad_busy++;
        tick();
      end
      start = 1'b0;
      chk("repulse done count", nd, 1);
      chk("repulse busy window", bad_busy, 0);
    end

    // Scenario 5: reset pulse mid-run.
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 7) tick();
    chk("pre-reset slot_valid", slot_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_quiet("mid reset");
    tick();
    check_quiet("after reset");
    run_check(-1, 0, 16);

    // Scenario 6: R=4 covers the whole matrix with 9 slots per row.
    begin
      int ns, nc, nfr, nfc, nlc, got;
      ns  = 0;
      nc  = 0;
      nfr = 0;
      nfc = 0;
      nlc = 0;
      got = -1;
      start2 = 1'b1;
      cyc    = 0;
      tick();
      start2 = 1'b0;
      for (int n = 0; n < 60; n++) begin
        tick();
        if (slot_valid2) ns++;
        if (cell_valid2) nc++;
        if (first_row2) nfr++;
        if (first_col2) nfc++;
        if (last_cell2) nlc++;
        if (done2 && got < 0) got = cyc;
      end
      chk("wide slots", ns, 36);
      chk("wide cells", nc, 16);
      chk("wide first_row", nfr, 4);
      chk("wide first_col", nfc, 4);
      chk("wide last_cell", nlc, 1);
      chk("wide done cycle", got, 40);
      chk("wide idle busy", busy2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
